// File: rtl/byte_ram_streamer_pkg.sv
// Shared types for the puzzle-input byte RAM read streamer: ROM addressing,
// command length and streamer state encoding.
package byte_ram_streamer_pkg;

    localparam int ROM_DEPTH = 16;
    localparam int ROM_AW    = $clog2(ROM_DEPTH);
    localparam int LEN_W     = $clog2(ROM_DEPTH + 1);

    typedef logic [ROM_AW-1:0] RomAddr_t;
    typedef logic [LEN_W-1:0]  Len_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } StreamerState_t;

    // ROM_DEPTH need not be a power of two, so wrap explicitly.
    function automatic RomAddr_t rom_addr_next(input RomAddr_t addr);
        if (addr == RomAddr_t'(ROM_DEPTH - 1)) begin
            rom_addr_next = RomAddr_t'(0);
        end else begin
            rom_addr_next = addr + RomAddr_t'(1);
        end
    endfunction

endpackage

// File: rtl/byte_stream_fifo.sv
// Small synchronous FIFO carrying a byte plus its end-of-command flag.
// Pushes to a full FIFO and pops from an empty one are ignored.
module byte_stream_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic [7:0]                   push_data_i,
    input  logic                         push_last_i,
    input  logic                         pop_i,
    output logic [7:0]                   head_data_o,
    output logic                         head_last_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]       data_mem_q [DEPTH];
    logic [DEPTH-1:0] last_mem_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            ptr_next = PW'(0);
        end else begin
            ptr_next = ptr + PW'(1);
        end
    endfunction

    assign push_ok_s   = push_i && (count_q != CW'(DEPTH));
    assign pop_ok_s    = pop_i && (count_q != CW'(0));
    assign head_data_o = data_mem_q[rd_ptr_q];
    assign head_last_o = last_mem_q[rd_ptr_q];
    assign empty_o     = (count_q == CW'(0));
    assign count_o     = count_q;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            data_mem_q[wr_ptr_q] <= push_data_i;
            last_mem_q[wr_ptr_q] <= push_last_i;
        end
    end

endmodule

// File: rtl/byte_ram_streamer.sv
// Reads Length bytes from the input byte RAM starting at StartAddr and
// presents them as a valid/ready stream, optionally stopping at a sentinel.
module byte_ram_streamer
    import byte_ram_streamer_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 4,
    parameter bit         TERM_ENABLE = 1'b0,
    parameter logic [7:0] TERM_BYTE   = 8'h00
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  RomAddr_t   start_addr_i,
    input  Len_t       length_i,
    output logic       busy_o,
    output logic       done_o,
    output RomAddr_t   ram_read_addr_o,
    output logic       ram_read_enable_o,
    input  logic [7:0] ram_read_data_i,
    output logic [7:0] out_data_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       out_last_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    StreamerState_t state_q, state_d;
    RomAddr_t       addr_q, addr_d;
    Len_t           rem_q, rem_d;
    logic           ren_q, ren_d;
    logic           ren_last_q, ren_last_d;
    logic           pend_q, pend_d;
    logic           pend_last_q, pend_last_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;

    logic [CW-1:0]  fifo_count_s;
    logic           fifo_empty_s;
    logic [7:0]     head_data_s;
    logic           head_last_s;
    logic           pop_s;
    logic           push_s;
    logic           push_last_s;
    logic           term_hit_s;
    logic           clr_s;
    logic [CW:0]    occ_next_s;

    assign pop_s       = !fifo_empty_s && out_ready_i;
    assign push_s      = pend_q;
    assign term_hit_s  = TERM_ENABLE && pend_q && (ram_read_data_i == TERM_BYTE);
    assign push_last_s = pend_last_q || term_hit_s;
    assign clr_s       = (state_q == IDLE) && start_i;
    assign occ_next_s  = {1'b0, fifo_count_s} + {{CW{1'b0}}, push_s} - {{CW{1'b0}}, pop_s};

    byte_stream_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (reset_i),
        .clr_i       (clr_s),
        .push_i      (push_s),
        .push_data_i (ram_read_data_i),
        .push_last_i (push_last_s),
        .pop_i       (pop_s),
        .head_data_o (head_data_s),
        .head_last_o (head_last_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_count_s)
    );

    // Next-state logic. Read enable is registered, so the issue decision for
    // the next cycle uses next-cycle occupancy plus the read issued this cycle.
    always_comb begin
        state_d     = state_q;
        addr_d      = ren_q ? rom_addr_next(addr_q) : addr_q;
        rem_d       = rem_q;
        ren_d       = 1'b0;
        ren_last_d  = 1'b0;
        pend_d      = ren_q;
        pend_last_d = ren_last_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d = start_addr_i;
                    if (length_i == Len_t'(0)) begin
                        state_d = FINISH;
                    end else begin
                        state_d    = STREAM;
                        ren_d      = 1'b1;
                        ren_last_d = (length_i == Len_t'(1));
                        rem_d      = length_i - Len_t'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (term_hit_s) begin
                    // Drop the read issued behind the sentinel.
                    state_d     = DRAIN;
                    rem_d       = Len_t'(0);
                    pend_d      = 1'b0;
                    pend_last_d = 1'b0;
                end else if (rem_q == Len_t'(0)) begin
                    state_d = DRAIN;
                end else if ((occ_next_s + {{CW{1'b0}}, ren_q}) < (CW+1)'(FIFO_DEPTH)) begin
                    ren_d      = 1'b1;
                    ren_last_d = (rem_q == Len_t'(1));
                    rem_d      = rem_q - Len_t'(1);
                end else begin
                    state_d = STREAM;
                end
            end
            DRAIN: begin
                if (term_hit_s) begin
                    pend_d      = 1'b0;
                    pend_last_d = 1'b0;
                end else begin
                    pend_d = ren_q;
                end
                if ((occ_next_s == (CW+1)'(0)) && !pend_d) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            FINISH: begin
                // Entry from DRAIN already raised Done; a zero-length command
                // arrives with Done low and pulses it here.
                if (done_q) begin
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Control state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            addr_q      <= RomAddr_t'(0);
            rem_q       <= Len_t'(0);
            ren_q       <= 1'b0;
            ren_last_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            ren_q       <= ren_d;
            ren_last_q  <= ren_last_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign ram_read_addr_o   = addr_q;
    assign ram_read_enable_o = ren_q;
    assign out_valid_o       = !fifo_empty_s;
    assign out_data_o        = fifo_empty_s ? 8'h00 : head_data_s;
    assign out_last_o        = fifo_empty_s ? 1'b0 : head_last_s;

endmodule

// File: tb/tb_byte_ram_streamer.sv
// Randomised and directed bench for byte_ram_streamer with a behavioural
// RAM and a reference model built from the stream rules.
module tb_byte_ram_streamer;
    import byte_ram_streamer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    RomAddr_t   start_addr;
    Len_t       length;
    logic       busy;
    logic       done;
    RomAddr_t   raddr;
    logic       ren;
    logic [7:0] rdata = 8'h00;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    logic [7:0] mem [ROM_DEPTH];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ren) rdata <= mem[raddr];
    end

    byte_ram_streamer #(
        .FIFO_DEPTH  (4),
        .TERM_ENABLE (1'b1),
        .TERM_BYTE   (8'h00)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .start_i           (start),
        .start_addr_i      (start_addr),
        .length_i          (length),
        .busy_o            (busy),
        .done_o            (done),
        .ram_read_addr_o   (raddr),
        .ram_read_enable_o (ren),
        .ram_read_data_i   (rdata),
        .out_data_o        (out_data),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .out_last_o        (out_last)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return ((k % 3) == 1);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // One command: expected bytes are the Length bytes from start_addr
    // (wrapping), cut after the first 0x00 sentinel.
    task automatic run_cmd(input int a, input int len, input int mode, input int abort_after);
        logic [7:0] exp_q[$];
        int got_addr[$];
        int n, idx, first_v, first_hs, last_hs, done_k;
        bit stall_prev, aborted;
        logic [7:0] held_d;
        logic held_l;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(mem[(a + i) % ROM_DEPTH]);
            if (mem[(a + i) % ROM_DEPTH] == 8'h00) break;
        end
        n = exp_q.size();
        idx = 0; first_v = -1; first_hs = -1; last_hs = -1; done_k = -1;
        stall_prev = 1'b0; aborted = 1'b0; held_d = 8'h00; held_l = 1'b0;

        @(negedge clk);
        start = 1'b1; start_addr = RomAddr_t'(a); length = Len_t'(len);
        @(posedge clk);
        #1 start = 1'b0; out_ready = ready_for(mode, 1);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (ren) got_addr.push_back(int'(raddr));
            check_eq("busy_during", busy, 1);
            if (out_valid && first_v < 0) first_v = k;
            if (stall_prev) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_data", out_data, held_d);
                check_eq("hold_last", out_last, held_l);
            end
            if (out_valid && out_ready) begin
                check_eq("byte_in_range", int'(idx < n), 1);
                if (idx < n) begin
                    check_eq("data", out_data, exp_q[idx]);
                    check_eq("last", out_last, int'(idx == n - 1));
                end
                if (first_hs < 0) first_hs = k;
                last_hs = k;
                idx++;
            end
            stall_prev = out_valid && !out_ready;
            held_d = out_data; held_l = out_last;
            if (done) begin
                done_k = k;
                break;
            end
            if (abort_after > 0 && idx == abort_after) begin
                reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0; out_ready = 1'b1;
                @(negedge clk);
                check_eq("abort_valid", out_valid, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_done", done, 0);
                aborted = 1'b1;
                break;
            end
            if (k == 300) check_eq("timeout", k, -1);
            @(posedge clk);
            #1 out_ready = ready_for(mode, k + 1);
            if (k + 1 == 2) begin
                start = 1'b1; start_addr = RomAddr_t'(a + 5); length = Len_t'(1);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!aborted) begin
            check_eq("done_seen", int'(done_k > 0), 1);
            check_eq("byte_count", idx, n);
            if (n == 0) begin
                check_eq("zero_done_lat", done_k, 2);
                check_eq("zero_no_valid", first_v, -1);
                check_eq("zero_no_reads", got_addr.size(), 0);
            end else begin
                check_eq("first_valid_lat", first_v, 3);
                check_eq("done_after_last", done_k, last_hs + 1);
                if (mode == 0) check_eq("back_to_back", last_hs - first_hs, n - 1);
                check_eq("reads_min", int'(got_addr.size() >= n), 1);
                if (n < len) check_eq("reads_max_term", int'(got_addr.size() <= n + 1), 1);
                else         check_eq("reads_exact", got_addr.size(), len);
                foreach (got_addr[i]) check_eq("read_addr", got_addr[i], (a + i) % ROM_DEPTH);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(negedge clk);
            check_eq("idle_busy", busy, 0);
            check_eq("idle_done", done, 0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_addr = RomAddr_t'(0); length = Len_t'(0);
        out_ready = 1'b1;
        for (int i = 0; i < ROM_DEPTH; i++) mem[i] = 8'h10 + 8'(i);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ren", ren, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_last", out_last, 0);
        check_eq("rst_addr", int'(raddr), 0);
        check_eq("rst_data", out_data, 0);

        mem[0] = 8'h31; mem[1] = 8'h32; mem[2] = 8'h0A; mem[3] = 8'h33;
        run_cmd(0, 4, 0, 0);
        run_cmd(0, 4, 1, 0);
        run_cmd(5, 0, 0, 0);
        mem[ROM_DEPTH-2] = 8'h55; mem[ROM_DEPTH-1] = 8'h66;
        run_cmd(ROM_DEPTH - 2, 4, 0, 0);
        run_cmd(9, ROM_DEPTH, 0, 0);
        run_cmd(3, ROM_DEPTH, 2, 0);
        mem[0] = 8'h41; mem[1] = 8'h00; mem[2] = 8'h42; mem[3] = 8'h43;
        run_cmd(0, 4, 0, 0);
        for (int i = 0; i < ROM_DEPTH; i++) mem[i] = 8'h80 + 8'(i);
        run_cmd(3, 10, 2, 2);
        run_cmd(7, 6, 0, 0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < ROM_DEPTH; i++)
                mem[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            run_cmd($urandom_range(0, ROM_DEPTH - 1), $urandom_range(0, ROM_DEPTH),
                    $urandom_range(0, 2), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
